// File: rtl/btb_nway.sv
// N-way set-associative branch target buffer: same-cycle lookup for the IF1 PC,
// commit-side modify/allocate and counter updates, plus a one-set-per-cycle flush.
module btb_nway #(
    parameter int SETS  = 32,
    parameter int WAYS  = 2,
    parameter int TAG_W = 12,
    localparam int IDX_W = $clog2(SETS),
    localparam int WW    = $clog2(WAYS)
) (
    input  logic             cpu_clk_i,
    input  logic             reset_i,
    input  logic [31:0]      if1_current_pc_i,
    input  logic             if1_valid,
    output logic [1:0]       btb_btype_o,
    output logic [1:0]       btb_bm_pred_o,
    output logic [31:0]      btb_target_o,
    output logic             btb_vld_o,
    output logic             btb_index_o,
    output logic [WW-1:0]    btb_way_o,
    input  logic [31:0]      c1_btb_vpc_i,
    input  logic [31:0]      c1_btb_target_i,
    input  logic [1:0]       c1_cntr_pred_i,
    input  logic             c1_bnch_tkn_i,
    input  logic [1:0]       c1_bnch_type_i,
    input  logic             c1_bnch_present_i,
    input  logic             c1_btb_mod_i,
    input  logic [WW-1:0]    c1_btb_way_i,
    input  logic             c1_btb_bm_i,
    input  logic             flush_i,
    output logic             flush_busy_o
);

    typedef enum logic {S_IDLE, S_FLUSH} fstate_t;

    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

    function automatic logic [IDX_W-1:0] set_of(input logic [31:0] pc);
        return pc[IDX_W+2:3];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
        return pc[31:32-TAG_W] ^ pc[IDX_W+2+TAG_W:IDX_W+3];
    endfunction

    // Storage: valid bits and replacement pointers are reset, payload is not
    logic [WAYS-1:0]  valid_q  [SETS];
    logic [WW-1:0]    rr_q     [SETS];
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [29:0]      tgt_mem  [WAYS][SETS];
    logic [1:0]       type_mem [WAYS][SETS];
    logic [1:0]       ctr_mem  [WAYS][SETS];
    logic             idx_mem  [WAYS][SETS];

    fstate_t          state_q, state_d;
    logic [IDX_W-1:0] fcnt_q, fcnt_d;
    logic             flush_clr;

    logic [31:0]      lk_pc;
    logic [IDX_W-1:0] lk_set, wr_set;
    logic [TAG_W-1:0] lk_tag, wr_tag;
    logic [WAYS-1:0]  hit;
    logic             hit_any;
    logic [WW-1:0]    hit_way;
    logic [WW-1:0]    victim;
    logic             all_valid;
    logic [1:0]       sat;

    logic             mod_go, cnt_go, upd, alloc;
    logic             data_we, tag_we, ctr_we, val_we, val_wd, rr_we;
    logic [WW-1:0]    wr_way, ctr_way;
    logic [1:0]       ctr_wd;
    logic             unused_bits;

    assign unused_bits = ^{c1_btb_target_i[1:0], c1_btb_vpc_i[1:0], lk_pc[1:0]};

    // A commit-side modify steals the single read port from IF1
    assign lk_pc  = c1_btb_mod_i ? c1_btb_vpc_i : if1_current_pc_i;
    assign lk_set = set_of(lk_pc);
    assign lk_tag = tag_of(lk_pc);
    assign wr_set = set_of(c1_btb_vpc_i);
    assign wr_tag = tag_of(c1_btb_vpc_i);

    always_comb begin
        hit     = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit[w] = valid_q[lk_set][w] & (tag_mem[w][lk_set] == lk_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit[w]) hit_way = WW'(w);
        end
    end

    assign hit_any = |hit;

    assign btb_btype_o   = type_mem[hit_way][lk_set];
    assign btb_bm_pred_o = ctr_mem[hit_way][lk_set];
    assign btb_target_o  = {tgt_mem[hit_way][lk_set], 2'b00};
    assign btb_index_o   = idx_mem[hit_way][lk_set];
    assign btb_way_o     = hit_way;

    // A branch stored in slot 0 is already behind a fetch that starts at slot 1
    assign btb_vld_o = hit_any & if1_valid & ~c1_btb_mod_i & ~flush_busy_o
                     & ~(~btb_index_o & if1_current_pc_i[2]);

    always_comb begin
        all_valid = &valid_q[wr_set];
        victim    = rr_q[wr_set];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[wr_set][w]) victim = WW'(w);
        end
    end

    always_comb begin
        sat = c1_cntr_pred_i;
        if (c1_bnch_tkn_i) begin
            if (c1_cntr_pred_i != 2'b11) sat = c1_cntr_pred_i + 2'b01;
        end else begin
            if (c1_cntr_pred_i != 2'b00) sat = c1_cntr_pred_i - 2'b01;
        end
    end

    assign mod_go  = c1_btb_mod_i & ~flush_busy_o;
    assign cnt_go  = c1_btb_bm_i & ~c1_btb_mod_i & ~flush_busy_o;
    assign upd     = mod_go & hit_any;
    assign alloc   = mod_go & ~hit_any & c1_bnch_present_i;
    assign wr_way  = upd ? hit_way : victim;
    assign data_we = upd | alloc;
    assign tag_we  = alloc;
    assign ctr_we  = data_we | cnt_go;
    assign ctr_way = cnt_go ? c1_btb_way_i : wr_way;
    assign ctr_wd  = (upd & ~c1_bnch_present_i) ? 2'b00 : sat;
    assign val_we  = data_we;
    assign val_wd  = alloc | c1_bnch_present_i;
    assign rr_we   = alloc & all_valid;

    // NOTE: non-blocking assignments for all state so every process sees pre-edge values
    always_ff @(posedge cpu_clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (flush_clr) begin
            valid_q[fcnt_q] <= '0;
        end else begin
            if (val_we) valid_q[wr_set][wr_way] <= val_wd;
            if (rr_we)  rr_q[wr_set] <= rr_q[wr_set] + WW'(1);
        end
    end

    // NOTE: payload arrays carry no reset; a cleared valid bit makes their contents irrelevant
    always_ff @(posedge cpu_clk_i) begin
        if (tag_we) tag_mem[wr_way][wr_set] <= wr_tag;
        if (data_we) begin
            tgt_mem[wr_way][wr_set]  <= c1_btb_target_i[31:2];
            type_mem[wr_way][wr_set] <= c1_bnch_type_i;
            idx_mem[wr_way][wr_set]  <= c1_btb_vpc_i[2];
        end
        if (ctr_we) ctr_mem[ctr_way][wr_set] <= ctr_wd;
    end

    always_ff @(posedge cpu_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // NOTE: defaults first so no path through this block infers a latch
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    state_d = S_FLUSH;
                    fcnt_d  = '0;
                end
            end
            S_FLUSH: begin
                if (flush_i) begin
                    fcnt_d = '0;
                end else if (fcnt_q == LAST_SET) begin
                    state_d = S_IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        flush_busy_o = 1'b0;
        flush_clr    = 1'b0;
        if (state_q == S_FLUSH) begin
            flush_busy_o = 1'b1;
            flush_clr    = 1'b1;
        end
    end

endmodule
